// File: rtl/boid_drawer_if.sv
// Bus bundle between the boid drawer and its environment: the sweep control
// handshake, the boid-memory read port and the frame-buffer write port.
interface boid_drawer_if #(
    parameter int NUM_BOIDS = 64
);
    localparam int AW = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;

    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] bm_addr;
    logic          bm_rd_en;
    logic [127:0]  bm_rdata;
    logic [18:0]   fb_addr;
    logic [7:0]    fb_data;
    logic          fb_we;
    logic          fb_ready;

    // The drawer side: issues reads and pixel writes, reports progress.
    modport master (
        input  start,
        output busy,
        output done,
        output bm_addr,
        output bm_rd_en,
        input  bm_rdata,
        output fb_addr,
        output fb_data,
        output fb_we,
        input  fb_ready
    );

    // The environment side: boid memory, frame buffer and sweep trigger.
    modport slave (
        output start,
        input  busy,
        input  done,
        input  bm_addr,
        input  bm_rd_en,
        output bm_rdata,
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        output fb_ready
    );
endinterface

// File: rtl/boid_drawer.sv
// Boid drawer: sweeps every boid record once per frame, erasing the pixel at
// the boid's previous position and drawing the pixel at its current position.
// Positions are signed Q16.16; only the integer part addresses the screen.
module boid_drawer #(
    parameter int         NUM_BOIDS   = 64,
    parameter int         FB_W        = 640,
    parameter int         FB_H        = 480,
    parameter logic [7:0] DRAW_COLOR  = 8'hFF,
    parameter logic [7:0] ERASE_COLOR = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    boid_drawer_if.master bus
);
    localparam int AW = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LATCH,
        ERASE,
        DRAW,
        NEXT
    } state_t;

    state_t        state_q;
    logic [AW-1:0] boidIdx_q;
    logic          busy_q;
    logic          done_q;
    logic          rdEn_q;
    logic [18:0]   fbAddr_q;
    logic [7:0]    fbData_q;
    logic          fbWe_q;
    logic [15:0]   curX_q;
    logic [15:0]   curY_q;
    logic [15:0]   prevX_q;
    logic [15:0]   prevY_q;
    logic [18:0]   curAddr_q;
    logic          curOn_q;

    logic [18:0]   curAddr_d;
    logic [18:0]   prevAddr_d;
    logic          curOn_d;
    logic          prevOn_d;

    // Row-major pixel address; the 640-wide screen uses y*512 + y*128 + x.
    // Off-screen inputs give a meaningless address that is never written.
    function automatic logic [18:0] pixelAddr(input logic [15:0] px, input logic [15:0] py);
        logic [18:0] xw;
        logic [18:0] yw;
        xw = {3'b000, px};
        yw = {3'b000, py};
        if (FB_W == 640) begin
            return (yw << 9) + (yw << 7) + xw;
        end else begin
            return (yw * 19'(FB_W)) + xw;
        end
    endfunction

    // A coordinate is drawable only if both integer parts are non-negative
    // and strictly inside the frame-buffer dimensions.
    function automatic logic onScreen(input logic [15:0] cx, input logic [15:0] cy);
        return !cx[15] && !cy[15] &&
               ({16'd0, cx} < 32'(FB_W)) && ({16'd0, cy} < 32'(FB_H));
    endfunction

    // Address and visibility of both positions, consumed in LATCH.
    always_comb begin
        curAddr_d  = pixelAddr(curX_q, curY_q);
        prevAddr_d = pixelAddr(prevX_q, prevY_q);
        curOn_d    = onScreen(curX_q, curY_q);
        prevOn_d   = onScreen(prevX_q, prevY_q);
    end

    // Sweep sequencer; every output is a register set on the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            boidIdx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdEn_q    <= 1'b0;
            fbAddr_q  <= '0;
            fbData_q  <= '0;
            fbWe_q    <= 1'b0;
            curX_q    <= '0;
            curY_q    <= '0;
            prevX_q   <= '0;
            prevY_q   <= '0;
            curAddr_q <= '0;
            curOn_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= FETCH;
                        busy_q    <= 1'b1;
                        boidIdx_q <= '0;
                        rdEn_q    <= 1'b1;
                    end
                end
                FETCH: begin
                    rdEn_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    curX_q  <= bus.bm_rdata[127:112];
                    curY_q  <= bus.bm_rdata[95:80];
                    prevX_q <= bus.bm_rdata[63:48];
                    prevY_q <= bus.bm_rdata[31:16];
                    state_q <= LATCH;
                end
                LATCH: begin
                    curAddr_q <= curAddr_d;
                    curOn_q   <= curOn_d;
                    fbAddr_q  <= prevAddr_d;
                    fbData_q  <= ERASE_COLOR;
                    fbWe_q    <= prevOn_d;
                    state_q   <= ERASE;
                end
                ERASE: begin
                    if (!fbWe_q || bus.fb_ready) begin
                        fbAddr_q <= curAddr_q;
                        fbData_q <= DRAW_COLOR;
                        fbWe_q   <= curOn_q;
                        state_q  <= DRAW;
                    end
                end
                DRAW: begin
                    if (!fbWe_q || bus.fb_ready) begin
                        fbWe_q  <= 1'b0;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (boidIdx_q == AW'(NUM_BOIDS - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        boidIdx_q <= boidIdx_q + 1'b1;
                        rdEn_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bm_addr  = boidIdx_q;
    assign bus.bm_rd_en = rdEn_q;
    assign bus.fb_addr  = fbAddr_q;
    assign bus.fb_data  = fbData_q;
    assign bus.fb_we    = fbWe_q;
endmodule

// File: tb/tb_boid_drawer.sv
// Directed bench for boid_drawer with a two-record boid memory: reset values,
// basic erase/draw, frame-buffer stall, off-screen skipping, screen corner,
// ignored restart and mid-stall reset.
module tb_boid_drawer;
    logic clk = 1'b0;
    logic reset;
    int   passCnt = 0;
    int   checkCnt = 0;
    int   cyc = 0;

    logic [127:0] bmem [2];
    logic [26:0]  wrLog [$];

    boid_drawer_if #(.NUM_BOIDS(2)) bus();

    boid_drawer #(
        .NUM_BOIDS(2),
        .FB_W(640),
        .FB_H(480),
        .DRAW_COLOR(8'hFF),
        .ERASE_COLOR(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock and cycle counter used for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Boid memory model: data appears one cycle after the read strobe.
    always @(posedge clk) if (bus.bm_rd_en) bus.bm_rdata <= bmem[bus.bm_addr];

    // Log every frame-buffer write that the buffer accepts.
    always @(posedge clk) if (!reset && bus.fb_we && bus.fb_ready) wrLog.push_back({bus.fb_addr, bus.fb_data});

    task automatic loadBoid(input int i, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] px, input logic [31:0] py);
        bmem[i] = {x, y, px, py};
    endtask

    // Leaves the caller #1 after the edge that moves the drawer into FETCH.
    task automatic pulseStart();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Runs until done is seen (bounded); doneCyc is -1000 on timeout.
    task automatic runSweep(output int doneCyc, output int weSeen, output int rdSeen);
        doneCyc = -1000;
        weSeen  = 0;
        rdSeen  = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.fb_we) weSeen++;
            if (bus.bm_rd_en) rdSeen++;
            if (bus.done) begin
                doneCyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passCnt++;
        checkCnt++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passCnt++;
        checkCnt++; if (bus.bm_rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b want 0", bus.bm_rd_en); else passCnt++;
        checkCnt++; if (bus.bm_addr !== 1'b0) $display("[TB] FAIL reset_bm_addr: got %h want 0", bus.bm_addr); else passCnt++;
        checkCnt++; if (bus.fb_we !== 1'b0) $display("[TB] FAIL reset_fb_we: got %b want 0", bus.fb_we); else passCnt++;
        checkCnt++; if (bus.fb_addr !== 19'd0) $display("[TB] FAIL reset_fb_addr: got %0d want 0", bus.fb_addr); else passCnt++;
        checkCnt++; if (bus.fb_data !== 8'h00) $display("[TB] FAIL reset_fb_data: got %h want 00", bus.fb_data); else passCnt++;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL idle_no_start_busy: got %b want 0", bus.busy); else passCnt++;
    endtask

    task automatic test_basic();
        int f, d, we, rd;
        logic [26:0] expW [4];
        expW[0] = {19'd3209, 8'h00};
        expW[1] = {19'd3210, 8'hFF};
        expW[2] = {19'd3859, 8'h00};
        expW[3] = {19'd3860, 8'hFF};
        loadBoid(0, 32'h000A0000, 32'h00050000, 32'h00090000, 32'h00050000);
        loadBoid(1, 32'h00140000, 32'h00060000, 32'h00130000, 32'h00060000);
        bus.fb_ready = 1'b1;
        wrLog.delete();
        pulseStart();
        f = cyc;
        checkCnt++; if (bus.busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b want 1", bus.busy); else passCnt++;
        checkCnt++; if (bus.bm_rd_en !== 1'b1) $display("[TB] FAIL basic_first_fetch: got %b want 1", bus.bm_rd_en); else passCnt++;
        checkCnt++; if (bus.bm_addr !== 1'b0) $display("[TB] FAIL basic_first_addr: got %h want 0", bus.bm_addr); else passCnt++;
        runSweep(d, we, rd);
        checkCnt++; if (d - f !== 12) $display("[TB] FAIL basic_latency: got %0d want 12", d - f); else passCnt++;
        checkCnt++; if (rd !== 2) $display("[TB] FAIL basic_reads: got %0d want 2", rd); else passCnt++;
        checkCnt++; if (wrLog.size() !== 4) $display("[TB] FAIL basic_write_count: got %0d want 4", wrLog.size()); else passCnt++;
        for (int i = 0; i < 4; i++) begin
            checkCnt++;
            if (i >= wrLog.size()) $display("[TB] FAIL basic_write%0d: got none want %h", i, expW[i]);
            else if (wrLog[i] !== expW[i]) $display("[TB] FAIL basic_write%0d: got %h want %h", i, wrLog[i], expW[i]);
            else passCnt++;
        end
        @(posedge clk); #1;
        checkCnt++; if (bus.done !== 1'b0) $display("[TB] FAIL basic_done_width: got %b want 0", bus.done); else passCnt++;
        checkCnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL basic_busy_after: got %b want 0", bus.busy); else passCnt++;
    endtask

    task automatic test_stall();
        int f, d, we, rd;
        logic [18:0] a0;
        logic [7:0]  d0;
        bus.fb_ready = 1'b0;
        wrLog.delete();
        pulseStart();
        f = cyc;
        for (int k = 0; k < 20 && !bus.fb_we; k++) begin
            @(posedge clk); #1;
        end
        checkCnt++; if (bus.fb_we !== 1'b1) $display("[TB] FAIL stall_we_seen: got %b want 1", bus.fb_we); else passCnt++;
        a0 = bus.fb_addr;
        d0 = bus.fb_data;
        checkCnt++; if (a0 !== 19'd3209) $display("[TB] FAIL stall_erase_addr: got %0d want 3209", a0); else passCnt++;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #1;
            checkCnt++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'd3209 || bus.fb_data !== 8'h00)
                $display("[TB] FAIL stall_hold_c%0d: got we=%b addr=%0d data=%h want we=1 addr=3209 data=00",
                         c, bus.fb_we, bus.fb_addr, bus.fb_data);
            else passCnt++;
        end
        bus.fb_ready = 1'b1;
        runSweep(d, we, rd);
        checkCnt++; if (d - f !== 15) $display("[TB] FAIL stall_latency: got %0d want 15", d - f); else passCnt++;
        checkCnt++; if (wrLog.size() !== 4) $display("[TB] FAIL stall_write_count: got %0d want 4", wrLog.size()); else passCnt++;
        checkCnt++;
        if (wrLog.size() < 2) $display("[TB] FAIL stall_order: got %0d writes want 2+", wrLog.size());
        else if (wrLog[0] !== {19'd3209, 8'h00} || wrLog[1] !== {19'd3210, 8'hFF})
            $display("[TB] FAIL stall_order: got %h,%h want %h,%h", wrLog[0], wrLog[1], {19'd3209, 8'h00}, {19'd3210, 8'hFF});
        else passCnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_offscreen();
        int f, d, we, rd;
        loadBoid(0, 32'hFFFF0000, 32'h00050000, 32'h00090000, 32'h01E00000);
        loadBoid(1, 32'h02800000, 32'h00000000, 32'h00000000, 32'hFFFB0000);
        bus.fb_ready = 1'b0;
        wrLog.delete();
        pulseStart();
        f = cyc;
        runSweep(d, we, rd);
        checkCnt++; if (d - f !== 12) $display("[TB] FAIL off_latency: got %0d want 12", d - f); else passCnt++;
        checkCnt++; if (we !== 0) $display("[TB] FAIL off_no_we: got %0d cycles want 0", we); else passCnt++;
        @(posedge clk); #1;
        loadBoid(0, 32'h00010000, 32'h00010000, 32'h02800000, 32'h00000000);
        loadBoid(1, 32'h00000000, 32'h01E00000, 32'h00020000, 32'h00000000);
        bus.fb_ready = 1'b1;
        wrLog.delete();
        pulseStart();
        runSweep(d, we, rd);
        checkCnt++; if (wrLog.size() !== 2) $display("[TB] FAIL mixed_write_count: got %0d want 2", wrLog.size()); else passCnt++;
        checkCnt++;
        if (wrLog.size() < 2) $display("[TB] FAIL mixed_writes: got %0d writes want 2", wrLog.size());
        else if (wrLog[0] !== {19'd641, 8'hFF} || wrLog[1] !== {19'd2, 8'h00})
            $display("[TB] FAIL mixed_writes: got %h,%h want %h,%h", wrLog[0], wrLog[1], {19'd641, 8'hFF}, {19'd2, 8'h00});
        else passCnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        int f, d, we, rd;
        logic [26:0] expW [4];
        expW[0] = {19'd307199, 8'h00};
        expW[1] = {19'd307199, 8'hFF};
        expW[2] = {19'd0, 8'h00};
        expW[3] = {19'd0, 8'hFF};
        loadBoid(0, 32'h027F0000, 32'h01DF0000, 32'h027F0000, 32'h01DF0000);
        loadBoid(1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
        bus.fb_ready = 1'b1;
        wrLog.delete();
        pulseStart();
        f = cyc;
        runSweep(d, we, rd);
        checkCnt++; if (d - f !== 12) $display("[TB] FAIL corner_latency: got %0d want 12", d - f); else passCnt++;
        checkCnt++; if (wrLog.size() !== 4) $display("[TB] FAIL corner_write_count: got %0d want 4", wrLog.size()); else passCnt++;
        for (int i = 0; i < 4; i++) begin
            checkCnt++;
            if (i >= wrLog.size()) $display("[TB] FAIL corner_write%0d: got none want %h", i, expW[i]);
            else if (wrLog[i] !== expW[i]) $display("[TB] FAIL corner_write%0d: got %h want %h", i, wrLog[i], expW[i]);
            else passCnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int f, d, rdCnt, doneCnt;
        loadBoid(0, 32'h000A0000, 32'h00050000, 32'h00090000, 32'h00050000);
        loadBoid(1, 32'h00140000, 32'h00060000, 32'h00130000, 32'h00060000);
        bus.fb_ready = 1'b1;
        pulseStart();
        f = cyc;
        d = -1000;
        rdCnt = 0;
        doneCnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.bm_rd_en) rdCnt++;
            if (bus.done) begin
                doneCnt++;
                d = cyc;
            end
            if (k == 4) bus.start = 1'b1;
            if (k == 5) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        checkCnt++; if (doneCnt !== 1) $display("[TB] FAIL restart_done_count: got %0d want 1", doneCnt); else passCnt++;
        checkCnt++; if (rdCnt !== 2) $display("[TB] FAIL restart_reads: got %0d want 2", rdCnt); else passCnt++;
        checkCnt++; if (d - f !== 12) $display("[TB] FAIL restart_latency: got %0d want 12", d - f); else passCnt++;
        checkCnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL restart_busy_end: got %b want 0", bus.busy); else passCnt++;
    endtask

    task automatic test_reset_mid();
        int f, d, we, rd;
        loadBoid(0, 32'h000A0000, 32'h00050000, 32'hFFFF0000, 32'h00050000);
        bus.fb_ready = 1'b0;
        pulseStart();
        for (int k = 0; k < 20 && !bus.fb_we; k++) begin
            @(posedge clk); #1;
        end
        checkCnt++;
        if (bus.fb_we !== 1'b1 || bus.fb_data !== 8'hFF || bus.fb_addr !== 19'd3210)
            $display("[TB] FAIL midreset_draw_stall: got we=%b addr=%0d data=%h want we=1 addr=3210 data=FF",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        else passCnt++;
        reset = 1'b1;
        #1;
        checkCnt++; if (bus.fb_we !== 1'b0) $display("[TB] FAIL midreset_we: got %b want 0", bus.fb_we); else passCnt++;
        checkCnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b want 0", bus.busy); else passCnt++;
        checkCnt++; if (bus.fb_addr !== 19'd0) $display("[TB] FAIL midreset_fb_addr: got %0d want 0", bus.fb_addr); else passCnt++;
        @(posedge clk); #1 reset = 1'b0;
        bus.fb_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkCnt++;
        if (bus.busy !== 1'b0 || bus.bm_rd_en !== 1'b0)
            $display("[TB] FAIL midreset_no_resume: got busy=%b rd=%b want 0 0", bus.busy, bus.bm_rd_en);
        else passCnt++;
        pulseStart();
        f = cyc;
        checkCnt++;
        if (bus.bm_rd_en !== 1'b1 || bus.bm_addr !== 1'b0)
            $display("[TB] FAIL midreset_restart: got rd=%b addr=%h want 1 0", bus.bm_rd_en, bus.bm_addr);
        else passCnt++;
        runSweep(d, we, rd);
        checkCnt++; if (d - f !== 12) $display("[TB] FAIL midreset_latency: got %0d want 12", d - f); else passCnt++;
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.fb_ready = 1'b0;
        bmem[0]      = '0;
        bmem[1]      = '0;
        test_reset();
        test_basic();
        test_stall();
        test_offscreen();
        test_corner();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule

// File: doc/boid_drawer.md
BOID_DRAWER -- requirements
Module: boid_drawer

Interface
REQ-001 SHALL have parameter NUM_BOIDS, default 64, number of boid records swept per frame.
REQ-002 SHALL have parameter FB_W, default 640, frame-buffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 480, frame-buffer height in pixels.
REQ-004 SHALL have parameter DRAW_COLOR, default 8'hFF, color written at the current position.
REQ-005 SHALL have parameter ERASE_COLOR, default 8'h00, color written at the previous position.
REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that begins a frame sweep.
REQ-009 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a sweep completes.
REQ-011 SHALL have port bm_addr, output, $clog2(NUM_BOIDS), boid-memory read address.
REQ-012 SHALL have port bm_rd_en, output, 1, boid-memory read strobe.
REQ-013 SHALL have port bm_rdata, input, 128, read data {x[127:96], y[95:64], px[63:32], py[31:0]}, valid exactly 1 cycle after bm_rd_en.
REQ-014 SHALL have port fb_addr, output, 19, frame-buffer (M10K) pixel address.
REQ-015 SHALL have port fb_data, output, 8, frame-buffer pixel color.
REQ-016 SHALL have port fb_we, output, 1, frame-buffer write request.
REQ-017 SHALL have port fb_ready, input, 1, frame-buffer accepts the write when fb_we and fb_ready are both high on a rising clk edge.

Function
REQ-018 SHALL treat positions as signed Q16.16 and use bits [31:16] as the signed integer pixel coordinate.
REQ-019 SHALL implement states IDLE, FETCH, WAIT, LATCH, ERASE, DRAW, NEXT.
REQ-020 SHALL, in IDLE, ignore everything except start; start moves to FETCH with index = 0 and busy = 1 from the next cycle.
REQ-021 SHALL, in FETCH, assert bm_rd_en for exactly one cycle with bm_addr = index, then go to WAIT.
REQ-022 SHALL, in WAIT, hold bm_rd_en low and capture bm_rdata at the end of the cycle, then go to LATCH.
REQ-023 SHALL, in LATCH, compute both pixel addresses as addr = y*FB_W + x, using shift-add for FB_W = 640 (y<<9 + y<<7 + x), then go to ERASE.
REQ-024 SHALL, in ERASE, drive fb_addr = previous address, fb_data = ERASE_COLOR and fb_we = 1, and hold all three stable until fb_ready is sampled high, then go to DRAW.
REQ-025 SHALL, in DRAW, drive the current address with DRAW_COLOR under the same hold-until-ready rule, then go to NEXT.
REQ-026 SHALL treat a coordinate as off-screen when x < 0, x >= FB_W, y < 0, or y >= FB_H.
REQ-027 SHALL, for an off-screen coordinate, keep fb_we low and leave ERASE or DRAW after one cycle.
REQ-028 SHALL, when previous and current addresses are equal and on-screen, still perform both writes in order: erase first, then draw.
REQ-029 SHALL, in NEXT, increment index and return to FETCH if index < NUM_BOIDS-1.
REQ-030 SHALL, in NEXT when index = NUM_BOIDS-1, pulse done for one cycle, drop busy, and return to IDLE.
REQ-031 SHALL ignore start while busy; no restart and no queuing.
REQ-032 SHALL give an unstalled sweep a duration of exactly 6*NUM_BOIDS cycles from the first FETCH to done.
REQ-033 SHALL keep fb_we low in every state except ERASE and DRAW.

Reset
REQ-034 SHALL, on reset assertion at any time including mid-sweep or mid-stall, immediately force state to IDLE and set busy = 0, done = 0, bm_rd_en = 0, bm_addr = 0, fb_we = 0, fb_addr = 0, fb_data = 0, and index = 0.
REQ-035 SHALL, after reset deassertion, begin a sweep only on a new start pulse; no partial sweep resumes.

Verification
REQ-036 SHALL pass: NUM_BOIDS = 2, fb_ready = 1, boid0 x = 0x000A0000, y = 0x00050000, px = 0x00090000, py = 0x00050000 -> writes (3209, 0x00) then (3210, 0xFF); done arrives 12 cycles after the first FETCH.
REQ-037 SHALL pass: fb_ready low for 3 cycles during ERASE -> fb_we, fb_addr, and fb_data stay stable for 4 cycles, and exactly one write is accepted.
REQ-038 SHALL pass: x = 0xFFFF0000 (-1) with py = 0x01E00000 (480) -> no fb_we for either write, and the sweep proceeds to NEXT.
REQ-039 SHALL pass: x = px = 639, y = py = 479 -> erase then draw at address 307199 in that order.
REQ-040 SHALL pass: start re-pulsed mid-sweep -> ignored, and a single done pulse is produced.
REQ-041 SHALL pass: reset asserted during DRAW with fb_ready = 0 -> fb_we = 0 and busy = 0 in the same cycle; the next start restarts at bm_addr = 0.
